lsu_mem_master: RTL

- Load/store initiator between the miniRV core's execute stage and the word-addressed, byte-strobed `ram` block.
- Accepts one load or store per valid/ready handshake and drives word-aligned `mem_addr`, `mem_wen`, `mem_wstrb` and lane-shifted `mem_wdata`.
- For loads, samples the RAM's combinational `mem_rdata`, then aligns, sign- or zero-extends and returns it on a response handshake.
- Accesses that cross a word boundary are split into two RAM cycles, or flagged as errors (see Optional Feature).

---
 rtl/lsu_mem_master.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_master.sv
// Load/store initiator between the execute stage and a word-addressed, byte-strobed RAM.
// Latency: aligned access responds 2 cycles after accept, split access 3, error 1.
// Backpressure: one request in flight; req_ready_o low until the response handshakes on resp_ready_i.
//
// Ports:
//   clk_i, reset_i         clock, synchronous active-high reset
//   req_*_i / req_ready_o  request handshake (we, size, unsigned, byte address, store data)
//   resp_*_o / resp_ready_i response handshake (extended load data, error flag)
//   mem_*_o, mem_rdata_i   word-aligned RAM port; mem_rdata_i is combinational for mem_addr_o
//
// Build option: define LSU_MISALIGN_SPLIT_EN to split word-boundary-crossing accesses into two
// RAM cycles; without it, any access that is not naturally aligned returns an error.
module lsu_mem_master #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_wen_o,
    output logic [3:0]        mem_wstrb_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       lo_q;
    logic              err_q;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic [31:0]       hi_q;
`endif

    // Request-time error detection, evaluated on the raw request in IDLE.
    logic req_err;
    always_comb begin
        req_err = (req_size_i == 2'b11);
`ifndef LSU_MISALIGN_SPLIT_EN
        if (req_size_i == 2'b01 && req_addr_i[0])
            req_err = 1'b1;
        if (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00)
            req_err = 1'b1;
`endif
    end

    // Byte-lane shift amount and base word address of the latched request.
    logic [4:0]        sh;
    logic [ADDR_W-1:0] word_addr;
    logic [3:0]        size_mask;
    assign sh        = {addr_q[1:0], 3'b000};
    assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

    always_comb begin
        unique case (size_q)
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    // Shifting into an 8-lane window: the upper half is what spills into the next word.
    logic [7:0]  strb8;
    logic [63:0] wd64;
    logic [3:0]  nbytes;
    logic        crossing;
    assign strb8    = {4'b0000, size_mask} << addr_q[1:0];
    assign wd64     = {32'b0, wdata_q} << sh;
    assign nbytes   = (size_q == 2'b00) ? 4'd1 : (size_q == 2'b01) ? 4'd2 : 4'd4;
    assign crossing = ({2'b00, addr_q[1:0]} + nbytes) > 4'd4;
`endif

    // Load extraction: byte-align the captured word(s), then extend to 32 bits.
    logic [31:0] ld_win;
    logic [31:0] ld_data;
`ifdef LSU_MISALIGN_SPLIT_EN
    assign ld_win = 32'({hi_q, lo_q} >> sh);
`else
    assign ld_win = lo_q >> sh;
`endif

    always_comb begin
        unique case (size_q)
            2'b00:   ld_data = uns_q ? {24'b0, ld_win[7:0]}  : {{24{ld_win[7]}},  ld_win[7:0]};
            2'b01:   ld_data = uns_q ? {16'b0, ld_win[15:0]} : {{16{ld_win[15]}}, ld_win[15:0]};
            default: ld_data = ld_win;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            err_q   <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            hi_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid_i) begin
                we_q    <= req_we_i;
                size_q  <= req_size_i;
                uns_q   <= req_unsigned_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                err_q   <= req_err;
            end
            if (state_q == ACC0 && !we_q)
                lo_q <= mem_rdata_i;
`ifdef LSU_MISALIGN_SPLIT_EN
            if (state_q == ACC1 && !we_q)
                hi_q <= mem_rdata_i;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        resp_rdata_o = '0;
        resp_err_o   = 1'b0;
        mem_addr_o   = '0;
        mem_wen_o    = 1'b0;
        mem_wstrb_o  = '0;
        mem_wdata_o  = '0;

        unique case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i)
                    state_d = req_err ? RESP : ACC0;
            end
            ACC0: begin
                mem_addr_o = word_addr;
                if (we_q) begin
                    mem_wen_o = 1'b1;
`ifdef LSU_MISALIGN_SPLIT_EN
                    mem_wstrb_o = strb8[3:0];
                    mem_wdata_o = wd64[31:0];
`else
                    mem_wstrb_o = size_mask << addr_q[1:0];
                    mem_wdata_o = wdata_q << sh;
`endif
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                state_d = crossing ? ACC1 : RESP;
`else
                state_d = RESP;
`endif
            end
            ACC1: begin
`ifdef LSU_MISALIGN_SPLIT_EN
                // Next word; the adder width makes the top word wrap to address 0.
                mem_addr_o = word_addr + ADDR_W'(4);
                if (we_q) begin
                    mem_wen_o   = 1'b1;
                    mem_wstrb_o = strb8[7:4];
                    mem_wdata_o = wd64[63:32];
                end
`endif
                state_d = RESP;
            end
            RESP: begin
                resp_valid_o = 1'b1;
                resp_err_o   = err_q;
                resp_rdata_o = (we_q || err_q) ? 32'b0 : ld_data;
                if (resp_ready_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A cycle under reset must never write, even mid-access.
        if (reset_i)
            mem_wen_o = 1'b0;
    end

endmodule
